ps2_device: RTL and testbench
=============================

# ps2_device

Device-side PS/2 engine: the keyboard/mouse end of the link, for loopback benches and device emulation. It generates `ps2_clk`, transmits device-to-host frames, and services host-to-device requests, including the ack bit. Both PS/2 lines are open-drain: the block drives 0 or releases.

## Interface

Parameters:
- `clk_freq`, default 50000000: system clock frequency in Hz.
- `ps2_freq`, default 12500: generated PS/2 clock frequency in Hz. `HALF = clk_freq/(2*ps2_freq)` must lie in 2..65535.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: reset, asynchronous, active-low.
- `tx_data`  in  8: byte to send to the host.
- `tx_valid`  in  1: `tx_data` is valid.
- `tx_ready`  out  1: the byte is accepted on the cycle where `tx_valid & tx_ready`.
- `tx_abort`  out  1: one-cycle pulse when a frame is dropped because of host inhibit. Tied 0 when `PS2_DEV_RETRY_EN` is defined.
- `rx_data`  out  8: last byte received from the host.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` updates.
- `rx_err`  out  1: parity error flag; valid only with `rx_valid`.
- `busy`  out  1: a frame is in progress in either direction.
- `ps2_clk`  inout  1: open-drain PS/2 clock.
- `ps2_data`  inout  1: open-drain PS/2 data.

## Operation

- Both line inputs pass through 2-FF synchronizers; every decision uses the synced values `sclk` and `sdat`.
- Bus-idle qualifier: `sclk` and `sdat` both high for HALF consecutive cycles.
- States: IDLE, TX_HI, TX_LO, RX_LO, RX_HI, ACK_LO, ACK_HI, ABORT.
- IDLE behaviour:
  - `tx_ready` = idle qualifier met and no host request pending.
  - Host request: `sclk` high and `sdat` low. It goes to RX_LO and takes priority over `tx_valid` in the same cycle.
- TX frame, 11 bits: start 0, data[0..7] LSB first, odd parity, stop 1.
  - Each bit is a TX_HI phase (data driven, clk released) of HALF cycles, then a TX_LO phase (clk driven 0) of HALF cycles.
  - After the stop bit's TX_LO, lines are released and the state returns to IDLE.
- Inhibit during TX: `sclk` low while the block is releasing clk in TX_HI. Response:
  - Go to ABORT and release both lines.
  - Return to IDLE once `sclk` is high again.
- RX frame:
  - RX_LO: clk driven 0 for HALF cycles.
  - RX_HI: clk released for HALF cycles; `sdat` is sampled on entry to RX_HI.
  - Order: 8 data bits LSB first, then parity, then stop.
  - Stop sampled 1: ACK_LO/ACK_HI with data driven 0 for one full clock period, then release and go to IDLE.
  - Stop sampled 0: no ack; clocking continues until `sdat` samples 1, then ACK.
  - `rx_valid` pulses on entry to ACK_LO. `rx_err` = 1 if received parity is not odd. Ack is sent even on a parity error.
- `reset` low at any time: lines released immediately (asynchronous), state IDLE, in-flight frame discarded.

## Timing

- Reset values: `tx_ready`=0, `tx_abort`=0, `rx_data`=0, `rx_valid`=0, `rx_err`=0, `busy`=0, both lines released.
- Accept to first TX_HI: 1 cycle.
- TX frame: 22·HALF cycles, then `tx_ready` rises after a further HALF idle cycles (+2 synchronizer cycles).
- Host request to first RX_LO: 3 cycles (synchronizer + 1).
- RX frame: 11 clock periods plus 1 ack period = 24·HALF cycles.
- Inhibit to line release: at most 3 cycles after the `ps2_clk` pin goes low.
- Phase counter is 16 bits and reloads with HALF-1 at each phase boundary.

## Configuration

- `PS2_DEV_RETRY_EN` defined:
  - An inhibited TX byte is retained.
  - The frame restarts from the start bit after the next bus-idle qualifier.
  - `tx_ready` stays 0 until the byte completes; `tx_abort` is constant 0.
- `PS2_DEV_RETRY_EN` undefined:
  - An inhibited byte is dropped and `tx_abort` pulses on entry to ABORT.
  - `tx_ready` returns to 1 after the idle qualifier.

## Test plan

All scenarios use clk_freq=50 MHz, ps2_freq=12.5 kHz, HALF=2000.

- **TX 0xAA.** Drive `tx_data`=0xAA with `tx_valid`. Required response:
  - 11 `ps2_clk` falling edges at a 4000-cycle period.
  - Data sampled at each falling edge: 0,0,1,0,1,0,1,0,1,1,1.
  - `tx_ready` high again 44000+2000(+2) cycles after accept.
- **RX 0xF4.** Bench holds clk low 5000 cycles, drives data low, releases clk, then shifts 0xF4 with parity 0 and stop 1. Required response:
  - `rx_valid` pulses once with `rx_data`=0xF4 and `rx_err`=0.
  - `ps2_data` is held low by the device for the 12th clock period.
- **RX parity error.** Same as above with parity bit 1. Required response: `rx_valid` with `rx_data`=0xF4 and `rx_err`=1; ack is still driven.
- **Inhibit mid-TX.** Bench pulls clk low during bit 4's high phase of 0xAA, holding it 6000 cycles. Required response:
  - Lines released within 3 cycles.
  - With the macro: a full 0xAA frame is resent after release and idle.
  - Without the macro: one `tx_abort` pulse, no resend.
- **Reset mid-frame.** Assert `reset` low during bit 5 of a TX. Required response: both lines released in the same cycle; all outputs 0; no further clock edges.
- **Simultaneous events.** `tx_valid` and a host request arrive in the same IDLE cycle. Required response: the RX frame completes first; 0xAA is accepted only afterwards.

Source files
------------

// File: rtl/ps2_device.sv
// Device-side PS/2 engine: generates ps2_clk, sends device frames, receives host frames with ack.
// Define PS2_DEV_RETRY_EN to resend a host-inhibited byte instead of dropping it.
module ps2_device #(
    parameter int clk_freq = 50000000,
    parameter int ps2_freq = 12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_abort,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    inout  wire        ps2_clk,
    inout  wire        ps2_data
);

    localparam int HALF = clk_freq / (2 * ps2_freq);
    localparam logic [15:0] H = 16'(HALF);
    localparam logic [15:0] HM1 = 16'(HALF - 1);
    localparam bit CHK_EN = (HALF >= 3);
    localparam logic [15:0] CHK = CHK_EN ? 16'(HALF - 3) : 16'd0;

    typedef enum logic [2:0] {
        IDLE, TX_HI, TX_LO, RX_LO, RX_HI, ACK_LO, ACK_HI, ABORT
    } state_t;

    state_t      state, state_n;
    logic [1:0]  c_sync, d_sync;
    logic        sclk, sdat;
    logic [15:0] idle_cnt, cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  tx_byte;
    logic [8:0]  rx_sh;
    logic        stop_bit;
    logic        idle_ok, done, host_req, inhibit;
    logic        tx_fire, start_tx, tx_bit;
    logic        clk_low, dat_low;
    logic [10:0] frame;

    assign sclk     = c_sync[1];
    assign sdat     = d_sync[1];
    assign idle_ok  = (idle_cnt == H);
    assign done     = (cnt == 16'd0);
    // cnt doubles as a short settle guard in IDLE so our own
    // just-released data line is not mistaken for a host request
    assign host_req = (state == IDLE) && sclk && !sdat && done;
    assign inhibit  = CHK_EN && (cnt <= CHK) && !sclk;
    assign tx_fire  = tx_valid && tx_ready;
    assign frame    = {1'b1, ~^tx_byte, tx_byte, 1'b0};
    assign tx_bit   = frame[bit_cnt];
    assign busy     = (state != IDLE);

`ifdef PS2_DEV_RETRY_EN
    logic pend;
    assign tx_ready = (state == IDLE) && idle_ok && !host_req && !pend;
    assign start_tx = tx_fire || ((state == IDLE) && pend && idle_ok && !host_req);
    assign tx_abort = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend <= 1'b0;
        else if (tx_fire) pend <= 1'b1;
        else if (state == TX_LO && state_n == IDLE) pend <= 1'b0;
    end
`else
    logic abort_q;
    assign tx_ready = (state == IDLE) && idle_ok && !host_req;
    assign start_tx = tx_fire;
    assign tx_abort = abort_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) abort_q <= 1'b0;
        else abort_q <= (state == TX_HI) && (state_n == ABORT);
    end
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (host_req) state_n = RX_LO;
                    else if (start_tx) state_n = TX_HI;
            TX_HI:  if (inhibit) state_n = ABORT;
                    else if (done) state_n = TX_LO;
            TX_LO:  if (done) state_n = (bit_cnt == 4'd10) ? IDLE : TX_HI;
            RX_LO:  if (done) state_n = RX_HI;
            RX_HI:  if (done) state_n = (bit_cnt == 4'd10 && stop_bit) ? ACK_LO : RX_LO;
            ACK_LO: if (done) state_n = ACK_HI;
            ACK_HI: if (done) state_n = IDLE;
            ABORT:  if (sclk) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        clk_low = (state == TX_LO) || (state == RX_LO) || (state == ACK_LO);
        dat_low = (state == ACK_LO) || (state == ACK_HI);
        if ((state == TX_HI || state == TX_LO) && !tx_bit) dat_low = 1'b1;
    end

    assign ps2_clk  = clk_low ? 1'b0 : 1'bz;
    assign ps2_data = dat_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            c_sync   <= 2'b11;
            d_sync   <= 2'b11;
            idle_cnt <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_byte  <= '0;
            rx_sh    <= '0;
            stop_bit <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            c_sync   <= {c_sync[0], ps2_clk};
            d_sync   <= {d_sync[0], ps2_data};
            state    <= state_n;
            rx_valid <= 1'b0;

            if (state != IDLE || !(sclk && sdat)) idle_cnt <= '0;
            else if (!idle_ok) idle_cnt <= idle_cnt + 16'd1;

            if (state_n != state) cnt <= (state_n == IDLE) ? 16'd2 : HM1;
            else if (!done) cnt <= cnt - 16'd1;

            if (state == IDLE) bit_cnt <= '0;
            else if (state == TX_LO && state_n == TX_HI) bit_cnt <= bit_cnt + 4'd1;
            else if (state == RX_HI && state_n == RX_LO && bit_cnt != 4'd10)
                bit_cnt <= bit_cnt + 4'd1;

            if (tx_fire) tx_byte <= tx_data;

            // bit 0 is the host start bit; 1..9 data+parity; 10 stop
            if (state == RX_LO && state_n == RX_HI) begin
                if (bit_cnt == 4'd10) stop_bit <= sdat;
                else if (bit_cnt != 4'd0) rx_sh <= {sdat, rx_sh[8:1]};
            end

            if (state == RX_HI && state_n == ACK_LO) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_sh[7:0];
                rx_err   <= ~^rx_sh;
            end
        end
    end

endmodule

// File: tb/tb_ps2_device.sv
// Self-checking bench for ps2_device: table of TX/RX frames plus inhibit,
// reset and simultaneous-request sequences, with a host model on the open-drain lines.
`timescale 1ns/1ps
module tb_ps2_device;

    localparam int H = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_abort, rx_valid, rx_err, busy;
    logic [7:0] rx_data;
    wire        ps2_clk, ps2_data;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;

    int checks = 0;
    int errors = 0;

    assign ps2_clk  = host_clk_low ? 1'b0 : 1'bz;
    assign ps2_data = host_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    always #5 clk = ~clk;

    ps2_device #(.clk_freq(800), .ps2_freq(20)) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_abort(tx_abort), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_err(rx_err), .busy(busy),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    typedef struct {
        bit         is_rx;
        logic [7:0] d;
        bit         par;
        int         extra;
        bit         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tx_run(input logic [7:0] d, output logic [10:0] bits,
                          output int nfall, output int per_bad, output int ready_n);
        int last;
        logic prev, c;
        bit got;
        bits = '0; nfall = 0; per_bad = 0; ready_n = -1; last = 0; got = 0;
        tx_data = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_ready) begin got = 1; break; end
        end
        chk("tx_accept", int'(got), 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        prev = 1'b1;
        for (int n = 1; n <= 30 * H; n++) begin
            @(negedge clk);
            c = ps2_clk;
            if (prev && !c) begin
                if (nfall < 11) bits[nfall] = ps2_data;
                if (nfall > 0 && n - last != 2 * H) per_bad++;
                last = n;
                nfall++;
            end
            prev = c;
            if (tx_ready) begin ready_n = n; break; end
        end
    endtask

    task automatic rx_run(input logic [7:0] d, input bit par, input int extra,
                          input bit direct, output logic [7:0] rxd, output bit rxe,
                          output int nvalid, output int ack_bad, output int ack_len,
                          output int frame_len, output int early);
        int nfall, start_n, tail;
        logic prev, c, bitv;
        bit ack_on, fin;
        rxd = 8'h00; rxe = 1'b0; nvalid = 0; ack_bad = 0; ack_len = 0;
        frame_len = -1; early = 0; nfall = 0; start_n = 0; tail = 0;
        ack_on = 0; fin = 0;
        if (!direct) begin
            @(negedge clk);
            host_clk_low = 1'b1;
            repeat (50) @(negedge clk);
            host_dat_low = 1'b1;
            repeat (4) @(negedge clk);
            host_clk_low = 1'b0;
        end else begin
            @(negedge clk);
            host_dat_low = 1'b1;
            repeat (2) @(negedge clk);
            tx_data = 8'hAA;
            tx_valid = 1'b1;
        end
        prev = 1'b1;
        for (int n = 0; n < (14 + extra) * 2 * H; n++) begin
            @(negedge clk);
            c = ps2_clk;
            if (tx_valid && tx_ready) early++;
            if (rx_valid) begin
                nvalid++;
                rxd = rx_data;
                rxe = rx_err;
            end
            if (fin) begin
                tail++;
                if (tail == 5) break;
            end else begin
                if (prev && !c) begin
                    if (nfall == 0) start_n = n;
                    if (nfall == 0) bitv = 1'b0;
                    else if (nfall <= 8) bitv = d[nfall-1];
                    else if (nfall == 9) bitv = par;
                    else bitv = (nfall >= 10 + extra);
                    if (nfall == 11 + extra) ack_on = 1;
                    host_dat_low = !bitv;
                    nfall++;
                end
                if (ack_on) begin
                    if (busy) begin
                        ack_len++;
                        if (ps2_data !== 1'b0) ack_bad++;
                    end else begin
                        frame_len = n - start_n;
                        fin = 1;
                    end
                end
            end
            prev = c;
        end
        host_dat_low = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits;
        logic [7:0]  rxd;
        bit          rxe;
        int nf, pb, rn, nv, ab, al, fl, ea, nab, ab_n;
        logic prev, c, dat_rel;

        vecs[0] = '{1'b0, 8'hAA, 1'b1, 0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 0, 1'b0};
        vecs[3] = '{1'b0, 8'h01, 1'b0, 0, 1'b0};
        vecs[4] = '{1'b1, 8'hF4, 1'b0, 0, 1'b0};
        vecs[5] = '{1'b1, 8'hF4, 1'b1, 0, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 1'b1, 0, 1'b0};
        vecs[7] = '{1'b1, 8'h81, 1'b1, 1, 1'b0};

        repeat (5) @(negedge clk);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_tx_abort", int'(tx_abort), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_err", int'(rx_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ps2_clk", int'(ps2_clk), 1);
        chk("rst_ps2_data", int'(ps2_data), 1);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].is_rx) begin
                tx_run(vecs[i].d, bits, nf, pb, rn);
                chk($sformatf("tx%0d_bits", i), int'(bits),
                    int'({1'b1, vecs[i].par, vecs[i].d, 1'b0}));
                chk($sformatf("tx%0d_falls", i), nf, 11);
                chk($sformatf("tx%0d_period", i), pb, 0);
                chk($sformatf("tx%0d_ready_time", i),
                    int'(rn >= 23 * H + 2 && rn <= 23 * H + 4), 1);
            end else begin
                rx_run(vecs[i].d, vecs[i].par, vecs[i].extra, 1'b0,
                       rxd, rxe, nv, ab, al, fl, ea);
                chk($sformatf("rx%0d_data", i), int'(rxd), int'(vecs[i].d));
                chk($sformatf("rx%0d_err", i), int'(rxe), int'(vecs[i].exp_err));
                chk($sformatf("rx%0d_valid_cnt", i), nv, 1);
                chk($sformatf("rx%0d_ack_low", i), ab, 0);
                chk($sformatf("rx%0d_ack_len", i), al, 2 * H);
                chk($sformatf("rx%0d_frame_len", i), fl, (12 + vecs[i].extra) * 2 * H);
            end
        end

        // host inhibit during the high phase of bit 4
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        nf = 0;
        prev = 1'b1;
        for (int n = 0; n < 20 * H; n++) begin
            @(negedge clk);
            c = ps2_clk;
            if (prev && !c) nf++;
            prev = c;
            if (nf == 4 && c) break;
        end
        repeat (8) @(negedge clk);
        host_clk_low = 1'b1;
        nab = 0; ab_n = 0; dat_rel = 1'b0;
        for (int n = 1; n <= 3 * H; n++) begin
            @(negedge clk);
            if (tx_abort) begin
                nab++;
                if (ab_n == 0) ab_n = n;
            end
            if (n == 4) dat_rel = ps2_data;
        end
        host_clk_low = 1'b0;
        chk("inh_data_released", int'(dat_rel), 1);
        chk("inh_busy_during", int'(busy), 1);
        nf = 0; bits = '0; prev = 1'b1;
        for (int n = 0; n < 40 * H; n++) begin
            @(negedge clk);
            c = ps2_clk;
            if (tx_abort) nab++;
            if (prev && !c) begin
                if (nf < 11) bits[nf] = ps2_data;
                nf++;
            end
            prev = c;
        end
`ifdef PS2_DEV_RETRY_EN
        chk("inh_abort_cnt", nab, 0);
        chk("inh_resend_falls", nf, 11);
        chk("inh_resend_bits", int'(bits), int'({1'b1, 1'b1, 8'hAA, 1'b0}));
`else
        chk("inh_abort_cnt", nab, 1);
        chk("inh_abort_time", int'(ab_n >= 1 && ab_n <= 3), 1);
        chk("inh_no_resend", nf, 0);
`endif
        chk("inh_ready_after", int'(tx_ready), 1);

        // reset during bit 5 of a TX frame
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        nf = 0;
        prev = 1'b1;
        for (int n = 0; n < 20 * H; n++) begin
            @(negedge clk);
            c = ps2_clk;
            if (prev && !c) nf++;
            prev = c;
            if (nf == 6) break;
        end
        chk("rstmid_data_driven", int'(ps2_data), 0);
        reset = 1'b0;
        #1;
        chk("rstmid_lines", int'({ps2_clk, ps2_data}), 3);
        chk("rstmid_outputs",
            int'({tx_ready, tx_abort, rx_valid, rx_err, busy, rx_data}), 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        nf = 0;
        prev = 1'b1;
        for (int n = 0; n < 15 * H; n++) begin
            @(negedge clk);
            c = ps2_clk;
            if (prev && !c) nf++;
            prev = c;
        end
        chk("rstmid_no_edges", nf, 0);
        chk("rstmid_ready", int'(tx_ready), 1);

        // host request and tx_valid in the same IDLE cycle
        rx_run(8'hF4, 1'b0, 0, 1'b1, rxd, rxe, nv, ab, al, fl, ea);
        chk("sim_no_early_accept", ea, 0);
        chk("sim_rx_data", int'(rxd), 32'hF4);
        chk("sim_rx_err", int'(rxe), 0);
        chk("sim_rx_valid_cnt", nv, 1);
        tx_run(8'hAA, bits, nf, pb, rn);
        chk("sim_tx_bits", int'(bits), int'({1'b1, 1'b1, 8'hAA, 1'b0}));
        chk("sim_tx_falls", nf, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
